// File: rtl/emif_amm_traffic_master.sv
// Avalon-MM traffic master for EMIF bring-up: writes an address-derived
// pattern over a range of bursts, then reads it back and checks every beat.
module emif_amm_traffic_master #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 576,
    parameter int BE_W       = 72,
    parameter int BURST_W    = 7,
    parameter int BURST_LEN  = 4,
    parameter int MAX_RD_OUT = 8
) (
    input  logic               emif_usr_clk,
    input  logic               emif_usr_reset_n,
    input  logic               local_cal_success,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [15:0]        num_bursts,
    input  logic [31:0]        seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic               proto_err,
    input  logic               amm_ready,
    output logic               amm_read,
    output logic               amm_write,
    output logic [ADDR_W-1:0]  amm_address,
    output logic [BURST_W-1:0] amm_burstcount,
    output logic [DATA_W-1:0]  amm_writedata,
    output logic [BE_W-1:0]    amm_byteenable,
    input  logic [DATA_W-1:0]  amm_readdata,
    input  logic               amm_readdatavalid
);

    localparam int LANES = DATA_W / 32;
    localparam int OW    = $clog2(MAX_RD_OUT + 1);
    localparam logic [ADDR_W-1:0]  STEP      = ADDR_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  wr_addr_q, wr_word_q, rd_addr_q, ret_addr_q;
    logic [ADDR_W-1:0]  cmp_addr_q, first_q;
    logic [BURST_W-1:0] wr_beat_q, ret_beat_q;
    logic [15:0]        nb_q, wr_burst_q, rd_cnt_q, err_q;
    logic [31:0]        seed_q;
    logic [OW-1:0]      outst_q;
    logic               cmp_vld_q, cmp_mis_q;
    logic               done_q, pass_q, proto_q;

    logic in_busy, go, wr_acc, rd_acc;
    logic rdv_ok, rdv_bad, ret_last, wr_last, rd_last;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       s
    );
        logic [DATA_W-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) begin
            p[k*32 +: 32] = (32'(a) + 32'(k) * 32'h0101_0101) ^ s;
        end
        return p;
    endfunction

    assign in_busy  = state_q inside {WRITE, READ, DRAIN};
    assign go       = (state_q == IDLE) && start && local_cal_success;
    assign wr_acc   = amm_write && amm_ready;
    assign rd_acc   = amm_read && amm_ready;
    assign rdv_ok   = in_busy && amm_readdatavalid && (outst_q != '0);
    assign rdv_bad  = in_busy && amm_readdatavalid && (outst_q == '0);
    assign ret_last = rdv_ok && (ret_beat_q == LAST_BEAT);
    assign wr_last  = wr_acc && (wr_beat_q == LAST_BEAT)
                      && (wr_burst_q == nb_q - 16'd1);
    assign rd_last  = rd_acc && (rd_cnt_q == nb_q - 16'd1);

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) state_q <= IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        amm_write     = 1'b0;
        amm_read      = 1'b0;
        amm_address   = '0;
        amm_writedata = '0;
        unique case (state_q)
            IDLE: begin
                if (go) state_d = (num_bursts == '0) ? DONE : WRITE;
            end
            WRITE: begin
                amm_write     = 1'b1;
                amm_address   = wr_addr_q;
                amm_writedata = pattern(wr_word_q, seed_q);
                if (wr_last) state_d = READ;
            end
            READ: begin
                amm_read    = outst_q < OW'(MAX_RD_OUT);
                amm_address = rd_addr_q;
                if (rd_last) state_d = DRAIN;
            end
            DRAIN: begin
                // wait for the last compare to land in err_count too
                if (outst_q == '0 && !cmp_vld_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            wr_addr_q  <= '0;
            wr_word_q  <= '0;
            rd_addr_q  <= '0;
            ret_addr_q <= '0;
            cmp_addr_q <= '0;
            first_q    <= '0;
            wr_beat_q  <= '0;
            ret_beat_q <= '0;
            nb_q       <= '0;
            wr_burst_q <= '0;
            rd_cnt_q   <= '0;
            err_q      <= '0;
            seed_q     <= '0;
            outst_q    <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_mis_q  <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            cmp_vld_q <= rdv_ok;
            if (rdv_ok) begin
                cmp_mis_q  <= amm_readdata != pattern(ret_addr_q, seed_q);
                cmp_addr_q <= ret_addr_q;
                ret_addr_q <= ret_addr_q + ADDR_W'(1);
                ret_beat_q <= ret_last ? '0 : ret_beat_q + BURST_W'(1);
            end
            if (cmp_vld_q && cmp_mis_q) begin
                if (err_q == '0) first_q <= cmp_addr_q;
                if (err_q != '1) err_q <= err_q + 16'd1;
            end
            if (rdv_bad) proto_q <= 1'b1;
            if (wr_acc) begin
                wr_word_q <= wr_word_q + ADDR_W'(1);
                if (wr_beat_q == LAST_BEAT) begin
                    wr_beat_q  <= '0;
                    wr_addr_q  <= wr_addr_q + STEP;
                    wr_burst_q <= wr_burst_q + 16'd1;
                end else begin
                    wr_beat_q <= wr_beat_q + BURST_W'(1);
                end
            end
            if (rd_acc) begin
                rd_addr_q <= rd_addr_q + STEP;
                rd_cnt_q  <= rd_cnt_q + 16'd1;
            end
            unique case ({rd_acc, ret_last})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
            if (state_q == DRAIN && state_d == DONE) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0) && !proto_q && !rdv_bad;
            end
            if (go) begin
                wr_addr_q  <= base_addr;
                wr_word_q  <= base_addr;
                rd_addr_q  <= base_addr;
                ret_addr_q <= base_addr;
                nb_q       <= num_bursts;
                seed_q     <= seed;
                wr_beat_q  <= '0;
                ret_beat_q <= '0;
                wr_burst_q <= '0;
                rd_cnt_q   <= '0;
                outst_q    <= '0;
                cmp_vld_q  <= 1'b0;
                err_q      <= '0;
                first_q    <= '0;
                proto_q    <= 1'b0;
                done_q     <= (num_bursts == '0);
                pass_q     <= (num_bursts == '0);
            end
        end
    end

    assign busy           = in_busy;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign proto_err      = proto_q;
    assign amm_burstcount = BURST_W'(BURST_LEN);
    assign amm_byteenable = '1;

endmodule

// File: tb/tb_emif_amm_traffic_master.sv
// Bench for emif_amm_traffic_master: Avalon slave with memory and read
// latency, plus a pattern/scoreboard model checked on every cycle.
module tb_emif_amm_traffic_master;

    localparam int AW  = 28;
    localparam int DW  = 576;
    localparam int BEW = 72;
    localparam int BRW = 7;
    localparam int BL  = 4;
    localparam int LN  = DW / 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cal = 1'b1;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic [31:0] seed = '0;
    logic busy, done, pass, proto_err;
    logic [15:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic amm_ready = 1'b0;
    logic amm_readdatavalid = 1'b0;
    logic [DW-1:0] amm_readdata = '0;
    logic amm_read, amm_write;
    logic [AW-1:0] amm_address;
    logic [BRW-1:0] amm_burstcount;
    logic [DW-1:0] amm_writedata;
    logic [BEW-1:0] amm_byteenable;

    emif_amm_traffic_master dut (
        .emif_usr_clk      (clk),
        .emif_usr_reset_n  (rst_n),
        .local_cal_success (cal),
        .start             (start),
        .base_addr         (base_addr),
        .num_bursts        (num_bursts),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .proto_err         (proto_err),
        .amm_ready         (amm_ready),
        .amm_read          (amm_read),
        .amm_write         (amm_write),
        .amm_address       (amm_address),
        .amm_burstcount    (amm_burstcount),
        .amm_writedata     (amm_writedata),
        .amm_byteenable    (amm_byteenable),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a,
                                          input logic [31:0] s);
        logic [DW-1:0] p;
        for (int k = 0; k < LN; k++)
            p[k*32 +: 32] = (32'(a) + 32'(k) * 32'h01010101) ^ s;
        return p;
    endfunction

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   due;
    } beat_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    beat_t         sl_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int cyc = 0, rdy_mode = 0, lat = 10;
    int tb_outst = 0, max_outst = 0, sl_beat = 0, wbeat = 0;
    int wr_acc_n = 0, rd_acc_n = 0, cmd_cycles = 0;
    int first_wr_cyc = -1, last_wr_cyc = -1, rd_before_data = -1;
    int t_nb = 0, exp_err = 0;
    bit cor_en = 0, spur_en = 0, exp_proto = 0;
    logic [AW-1:0] cor_addr = '0, exp_first = '0;
    logic prev_pend = 0, prev_rd = 0, prev_wr = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd = '0;

    // slave drive first, then the bus check for the coming rising edge
    always @(negedge clk) begin
        beat_t hb;
        wr_t ew;
        logic [DW-1:0] rd, one;
        cyc++;
        if (rdy_mode == 0) amm_ready = 1'b1;
        else if (rdy_mode == 1) amm_ready = (cyc % 2) == 0;
        else amm_ready = $urandom_range(0, 99) < 70;
        amm_readdatavalid = 1'b0;
        amm_readdata = '0;
        if (sl_q.size() > 0 && sl_q[0].due <= 32'(cyc)) begin
            hb = sl_q.pop_front();
            rd = mem.exists(hb.a) ? mem[hb.a] : '0;
            if (cor_en && busy && hb.a == cor_addr) begin
                one = 1;
                rd = rd ^ (one << $urandom_range(0, DW - 1));
                if (exp_err == 0) exp_first = hb.a;
                exp_err++;
            end
            if (rd_before_data < 0) rd_before_data = rd_acc_n;
            amm_readdatavalid = 1'b1;
            amm_readdata = rd;
            sl_beat++;
            if (sl_beat == BL) begin
                sl_beat = 0;
                tb_outst--;
            end
        end else if (spur_en && busy && tb_outst == 0 && rd_acc_n == t_nb) begin
            spur_en = 0;
            exp_proto = 1;
            amm_readdatavalid = 1'b1;
            amm_readdata = {LN{$urandom()}};
        end
        if (rst_n) begin
            if (amm_read || amm_write) begin
                cmd_cycles++;
                chk("rd_wr_excl", amm_read & amm_write, 0);
                chk("burstcount", amm_burstcount, BL);
                chk("byteenable", &amm_byteenable, 1);
            end
            if (prev_pend)
                chk("hold_stable", amm_read == prev_rd && amm_write == prev_wr
                    && amm_address == prev_addr && amm_writedata == prev_wd, 1);
            if (amm_write && amm_ready) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_acc_n++;
                if (exp_wr.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", amm_address, ew.a);
                    chk("wr_data", amm_writedata == ew.d, 1);
                end
                mem[amm_address + AW'(wbeat)] = amm_writedata;
                wbeat = (wbeat + 1) % BL;
            end
            if (amm_read && amm_ready) begin
                rd_acc_n++;
                if (exp_rd.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", amm_address, exp_rd.pop_front());
                for (int j = 0; j < BL; j++)
                    sl_q.push_back('{a: amm_address + AW'(j), due: 32'(cyc + lat)});
                tb_outst++;
                if (tb_outst > max_outst) max_outst = tb_outst;
            end
        end
        prev_pend = rst_n && (amm_read || amm_write) && !amm_ready;
        prev_rd = amm_read;
        prev_wr = amm_write;
        prev_addr = amm_address;
        prev_wd = amm_writedata;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        sl_q.delete();
        tb_outst = 0;
        sl_beat = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic launch(input logic [AW-1:0] b, input int n,
                          input logic [31:0] s, input int mode, input int l,
                          input bit ce, input logic [AW-1:0] ca, input bit sp);
        @(posedge clk);
        #1;
        exp_wr.delete();
        exp_rd.delete();
        mem.delete();
        for (int bi = 0; bi < n; bi++) begin
            exp_rd.push_back(b + AW'(bi * BL));
            for (int j = 0; j < BL; j++)
                exp_wr.push_back('{a: b + AW'(bi * BL),
                                   d: pat(b + AW'(bi * BL + j), s)});
        end
        rdy_mode = mode; lat = l; cor_en = ce; cor_addr = ca; spur_en = sp;
        t_nb = n; exp_err = 0; exp_first = '0; exp_proto = 0;
        wr_acc_n = 0; rd_acc_n = 0; first_wr_cyc = -1; last_wr_cyc = -1;
        rd_before_data = -1; max_outst = 0; wbeat = 0; sl_beat = 0;
        tb_outst = 0;
        base_addr = b; num_bursts = 16'(n); seed = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_check(input string nm);
        bit ok = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_done"}, ok, 1);
        if (!ok) begin
            do_reset();
            return;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pass"}, pass, (exp_err == 0) && !exp_proto);
        chk({nm, "_err_count"}, err_count, exp_err);
        chk({nm, "_first_err"}, first_err_addr, exp_first);
        chk({nm, "_proto"}, proto_err, exp_proto);
        chk({nm, "_wr_left"}, exp_wr.size(), 0);
        chk({nm, "_rd_left"}, exp_rd.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] w;
        int c0, n;
        logic [AW-1:0] b;
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_read", amm_read, 0);
        chk("rst_write", amm_write, 0);
        chk("rst_burstcount", amm_burstcount, BL);
        chk("rst_wdata", amm_writedata == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        launch(28'h0, 4, 32'h0, 0, 10, 0, '0, 0);
        finish_check("t1");
        chk("t1_beats", wr_acc_n, 16);
        chk("t1_consec", last_wr_cyc - first_wr_cyc, 15);
        w = mem[28'h5];
        chk("t1_w5_lane1", w[63:32], 32'h01010106);

        launch(28'h100, 5, 32'hDEADBEEF, 1, 10, 0, '0, 0);
        finish_check("t2");
        chk("t2_beats", wr_acc_n, 20);

        launch(28'h0, 4, 32'hA5A5A5A5, 0, 10, 1, 28'h9, 0);
        finish_check("t3");
        chk("t3_err_lit", err_count, 1);
        chk("t3_first_lit", first_err_addr, 28'h9);
        chk("t3_pass_lit", pass, 0);

        launch(28'h2000, 20, $urandom(), 0, 200, 0, '0, 0);
        finish_check("t4");
        chk("t4_rd_before_data", rd_before_data > 0 && rd_before_data <= 8, 1);
        chk("t4_max_outst", max_outst <= 8, 1);

        launch(28'hFFFFFFE, 1, 32'h12345678, 0, 5, 0, '0, 0);
        finish_check("t5");
        w = mem[28'hFFFFFFE];
        chk("t5_wFFFFFFE", w[31:0], 32'h1DCBA986);
        w = mem[28'h0];
        chk("t5_w0", w[31:0], 32'h12345678);
        w = mem[28'h1];
        chk("t5_w1", w[31:0], 32'h12345679);

        c0 = cmd_cycles;
        launch(28'h55, 0, 32'h0, 0, 5, 0, '0, 0);
        chk("t6_done", done, 1);
        chk("t6_pass", pass, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_bus", cmd_cycles - c0, 0);

        launch(28'h300, 6, 32'h0BADF00D, 0, 200, 0, '0, 0);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (tb_outst == 3) break;
        end
        chk("t7_outst3", tb_outst, 3);
        rst_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_pass", pass, 0);
        chk("t7_err", err_count, 0);
        chk("t7_first", first_err_addr, 0);
        chk("t7_proto", proto_err, 0);
        chk("t7_read", amm_read, 0);
        chk("t7_write", amm_write, 0);
        chk("t7_addr", amm_address, 0);
        chk("t7_wdata", amm_writedata == '0, 1);
        chk("t7_burstcount", amm_burstcount, BL);
        chk("t7_be", &amm_byteenable, 1);
        exp_wr.delete();
        exp_rd.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (sl_q.size() == 0) break;
        end
        chk("t7_flushed", sl_q.size(), 0);
        chk("t7_proto_after", proto_err, 0);
        chk("t7_done_after", done, 0);

        cal = 1'b0;
        c0 = cmd_cycles;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_done", done, 0);
        chk("t8_no_bus", cmd_cycles - c0, 0);
        cal = 1'b1;

        launch(28'h40, 3, 32'h0F0F0F0F, 0, 12, 0, '0, 1);
        finish_check("t9");
        chk("t9_spur_sent", spur_en, 0);
        chk("t9_proto_lit", proto_err, 1);
        chk("t9_pass_lit", pass, 0);

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 12);
            b = AW'($urandom());
            launch(b, n, $urandom(), $urandom_range(0, 2), $urandom_range(1, 30),
                   1'($urandom_range(0, 1)), b + AW'($urandom_range(0, n * BL - 1)), 0);
            finish_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
